// File: rtl/wr_arb_pkg.sv
// Shared types and constants for the async-FIFO write-port arbiter.
// Optional statistics counters are enabled with WR_ARB_STATS_EN.
package wr_arb_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int          STAT_W   = 16;
  localparam logic [15:0] STAT_MAX = 16'hFFFF;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above last_i,
// wrapping modulo NREQ.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    j      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_i) + k) % NREQ;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = IW'(j);
      end
    end
    if (any_o) pick_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter for the async-FIFO write port.
// Define WR_ARB_STATS_EN to add per-requester accepted-word counters.
module fifo_wr_arbiter
  import wr_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 8,
  parameter int MAXBURST = 8
) (
  input  logic                   wclk,
  input  logic                   wreset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   wfull,
  output logic                   winc,
  output logic [DWIDTH-1:0]      wdata,
  output logic [NREQ-1:0]        grant,
`ifdef WR_ARB_STATS_EN
  input  logic                   stat_clr,
  output logic [NREQ*STAT_W-1:0] stat_cnt,
`endif
  output logic                   busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST + 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [BW-1:0]   burst_q, burst_d;

  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            xfer;
  logic            rel;
  logic [BW-1:0]   burst_nxt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // last_q doubles as the owner index while in GRANT
  assign xfer = (state_q == GRANT) & req_valid[last_q] & ~wfull;
  assign burst_nxt = burst_q + BW'(1);
  assign rel = xfer &
    (req_last[last_q] | (burst_nxt == BW'(MAXBURST)));

  always_ff @(posedge wclk or negedge wreset_n) begin
    if (!wreset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick;
          last_d  = pick_idx;
        end
      end
      GRANT: begin
        if (xfer) burst_d = burst_nxt;
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          burst_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = grant_q & {NREQ{~wfull}};
  assign winc = (|(grant_q & req_valid)) & ~wfull;
  assign grant = grant_q;
  assign busy = (state_q == GRANT);

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) wdata = wdata | req_data[i*DWIDTH +: DWIDTH];
    end
  end

`ifdef WR_ARB_STATS_EN
  logic [NREQ*STAT_W-1:0] stat_q;

  always_ff @(posedge wclk or negedge wreset_n) begin
    if (!wreset_n) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stat_clr) begin
          stat_q[i*STAT_W +: STAT_W] <= '0;
        end else if (req_valid[i] && req_ready[i] &&
                     stat_q[i*STAT_W +: STAT_W] != STAT_MAX) begin
          stat_q[i*STAT_W +: STAT_W] <=
            stat_q[i*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DWIDTH=8,
// MAXBURST=8); WR_ARB_STATS_EN also runs the saturation test.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wreset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        wfull = 1'b0;
  logic        winc;
  logic [7:0]  wdata;
  logic [3:0]  grant;
  logic        busy;
`ifdef WR_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [63:0] stat_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;

  logic [8:0] q [4][$];
  logic [7:0] wlog [$];

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(4), .DWIDTH(8), .MAXBURST(8)) dut (
    .wclk      (wclk),
    .wreset_n  (wreset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
`ifdef WR_ARB_STATS_EN
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = q[i][0][7:0];
        req_last[i] = q[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    if (winc) wlog.push_back(wdata);
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) void'(q[i].pop_front());
    @(posedge wclk);
    #1;
    drive();
    #1;
  endtask

  task automatic do_reset();
    wreset_n = 1'b0;
    wfull = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    wlog.delete();
    drive();
`ifdef WR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge wclk);
    #3;
    wreset_n = 1'b1;
    #1;
  endtask

  logic [3:0] exp_g [10];
  logic [7:0] exp3 [10];
  int nw;

  initial begin
    // reset state
    do_reset();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_winc", winc, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_wdata", wdata, 8'h00);

    // single requester 2, three words
    q[2].push_back(9'h0A1);
    q[2].push_back(9'h0A2);
    q[2].push_back(9'h1A3);
    drive();
    #1;
    chk("t1_idle_grant", grant, 4'b0000);
    chk("t1_idle_winc", winc, 1'b0);
    tick();
    chk("t1_grant", grant, 4'b0100);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_w1", {winc, wdata}, {1'b1, 8'hA1});
    tick();
    chk("t1_w2", {winc, wdata}, {1'b1, 8'hA2});
    tick();
    chk("t1_w3", {winc, wdata}, {1'b1, 8'hA3});
    tick();
    chk("t1_rel_grant", grant, 4'b0000);
    chk("t1_rel_winc", winc, 1'b0);
    chk("t1_rel_busy", busy, 1'b0);

    // all four with 1-word packets: 0,1,2,3,0
    do_reset();
    q[0].push_back(9'h150);
    q[0].push_back(9'h150);
    q[1].push_back(9'h151);
    q[2].push_back(9'h152);
    q[3].push_back(9'h153);
    drive();
    #1;
    exp_g = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0,
              4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    nw = 0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t2_grant%0d", k), grant, exp_g[k]);
      chk($sformatf("t2_winc%0d", k), winc, exp_g[k] != 4'h0);
      if (k % 2 == 1)
        chk($sformatf("t2_data%0d", k), wdata,
            8'h50 + 8'(((k - 1) / 2) % 4));
      if (winc) nw++;
      tick();
    end
    chk("t2_duty", nw, 5);

    // MAXBURST rotation: 1 streams, 3 has one word
    do_reset();
    for (int n = 1; n <= 20; n++) q[1].push_back(9'(8'h10 + n));
    q[3].push_back(9'h130);
    drive();
    #1;
    for (int c = 0; c < 14; c++) begin
      if (winc && wdata == 8'h30) chk("t3_g3", grant, 4'b1000);
      tick();
    end
    exp3 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
             8'h16, 8'h17, 8'h18, 8'h30, 8'h19};
    chk("t3_cnt", wlog.size() >= 10, 1'b1);
    for (int k = 0; k < 10 && k < wlog.size(); k++)
      chk($sformatf("t3_word%0d", k), wlog[k], exp3[k]);

    // wfull stall mid-packet from requester 0
    do_reset();
    for (int n = 1; n <= 8; n++) q[0].push_back({n == 8, 8'(8'h40 + n)});
    drive();
    #1;
    tick();
    tick();
    chk("t4_pre", {winc, wdata}, {1'b1, 8'h42});
    wfull = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4_winc%0d", c), winc, 1'b0);
      chk($sformatf("t4_rdy%0d", c), req_ready, 4'b0000);
      chk($sformatf("t4_gnt%0d", c), grant, 4'b0001);
      tick();
    end
    wfull = 1'b0;
    #1;
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("t4_run%0d", c), {winc, wdata},
          {1'b1, 8'(8'h42 + c)});
      tick();
    end
    chk("t4_end", grant, 4'b0000);
    chk("t4_len", wlog.size(), 8);
    for (int k = 0; k < 8 && k < wlog.size(); k++)
      chk($sformatf("t4_word%0d", k), wlog[k], 8'(8'h41 + k));

    // async reset mid-grant
    do_reset();
    for (int n = 1; n <= 4; n++) q[2].push_back(9'(8'h60 + n));
    drive();
    #1;
    tick();
    chk("t5_pre", {grant, winc}, {4'b0100, 1'b1});
    #2;
    wreset_n = 1'b0;
    #1;
    chk("t5_grant", grant, 4'b0000);
    chk("t5_winc", winc, 1'b0);
    chk("t5_busy", busy, 1'b0);
    q[0].push_back(9'h170);
    q[1].push_back(9'h171);
    drive();
    @(posedge wclk);
    #3;
    wreset_n = 1'b1;
    #1;
    tick();
    chk("t5_first", grant, 4'b0001);
    chk("t5_fdata", wdata, 8'h70);

`ifdef WR_ARB_STATS_EN
    do_reset();
    req_valid = 4'b0001;
    req_last = 4'b0000;
    repeat (79000) @(posedge wclk);
    #1;
    chk("st_sat", stat_cnt[15:0], 16'hFFFF);
    chk("st_other", stat_cnt[63:16], 48'h0);
    stat_clr = 1'b1;
    @(posedge wclk);
    #1;
    stat_clr = 1'b0;
    chk("st_clr", stat_cnt[15:0], 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
